// File: rtl/shifter_seq_sll.sv
// shifter_seq_sll: multi-cycle logical left shifter with a start/busy/done
// handshake. It runs one binary stage per clock (1, 2, 4, 8, 16 positions),
// so every operation takes SHAMT_W cycles regardless of the shift amount.
// Optional feature macro: SHIFTER_SRL_EN. When it is defined, a captured
// function code of 6'b000010 (SRL) makes the same stages shift right instead.
module shifter_seq_sll #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   dataA,
    input  logic [SHAMT_W-1:0] dataB,
    input  logic [5:0]         Signal,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   dataOut
);

    localparam int CNT_W = (SHAMT_W > 1) ? $clog2(SHAMT_W + 1) : 1;
    localparam logic [CNT_W-1:0] LAST_STAGE = CNT_W'(SHAMT_W - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [WIDTH-1:0]   acc;
    logic [SHAMT_W-1:0] amt;
    logic [CNT_W-1:0]   cnt;
    logic [SHAMT_W-1:0] stage_dist;
    logic [WIDTH-1:0]   stage_val;
    logic               accept;
    logic               last_stage;

`ifdef SHIFTER_SRL_EN
    logic [5:0]         fn;
`else
    // Function code has no effect in the left-only build.
    logic               unused_signal;
    assign unused_signal = ^Signal;
`endif

    assign busy = (state == SHIFT);
    assign done = (state == DONE);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and the value produced by the current shift stage.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        last_stage = (cnt == LAST_STAGE);
        stage_dist = SHAMT_W'(1) << cnt;
        stage_val  = acc;

        if (amt[cnt]) begin
`ifdef SHIFTER_SRL_EN
            if (fn == 6'b000010) begin
                stage_val = acc >> stage_dist;
            end else begin
                stage_val = acc << stage_dist;
            end
`else
            stage_val = acc << stage_dist;
`endif
        end

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = SHIFT;
                end else begin
                    state_next = IDLE;
                end
            end
            SHIFT: begin
                if (last_stage) begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand capture, per-stage shifting and the result register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc     <= '0;
            amt     <= '0;
            cnt     <= '0;
            dataOut <= '0;
`ifdef SHIFTER_SRL_EN
            fn      <= '0;
`endif
        end else if (accept) begin
            acc <= dataA;
            amt <= dataB;
            cnt <= '0;
`ifdef SHIFTER_SRL_EN
            fn  <= Signal;
`endif
        end else if (state == SHIFT) begin
            acc <= stage_val;
            cnt <= cnt + CNT_W'(1);
            if (last_stage) begin
                dataOut <= stage_val;
            end
        end
    end

endmodule

// File: tb/tb_shifter_seq_sll.sv
// Directed testbench for shifter_seq_sll: reset, latency/handshake, shift
// values, start ignored while busy, back-to-back and reset mid-operation.
module tb_shifter_seq_sll;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] dataA;
    logic [4:0]  dataB;
    logic [5:0]  Signal;
    logic        busy;
    logic        done;
    logic [31:0] dataOut;

    int errors;
    int checks;

    shifter_seq_sll #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .dataA   (dataA),
        .dataB   (dataB),
        .Signal  (Signal),
        .busy    (busy),
        .done    (done),
        .dataOut (dataOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one op and observe 10 negedges after the accepting edge E0.
    // Observation n follows edge En. lat = -1 if done never seen.
    task automatic run_op(input logic [31:0] a, input logic [4:0] b, input logic [5:0] sig,
                          output int lat, output int busy_cnt, output int done_cnt,
                          output logic [31:0] res);
        lat = -1; busy_cnt = 0; done_cnt = 0; res = 'x;
        @(negedge clk);
        dataA = a; dataB = b; Signal = sig; start = 1'b1;
        @(posedge clk);
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (lat < 0) begin
                    lat = n;
                    res = dataOut;
                end
            end
        end
    endtask

    task automatic test_reset();
        // No clock edge has happened yet at this point.
        #2;
        checks++; if (dataOut !== 32'h0) begin errors++; $display("FAIL reset_dataOut got=%h exp=%h", dataOut, 32'h0); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_shift_msb();
        int lat, bc, dc; logic [31:0] res;
        run_op(32'h0000_0001, 5'd31, 6'd0, lat, bc, dc, res);
        checks++; if (bc !== 5) begin errors++; $display("FAIL msb_busy_cycles got=%0d exp=5", bc); end
        checks++; if (lat !== 5) begin errors++; $display("FAIL msb_latency got=%0d exp=5", lat); end
        checks++; if (dc !== 1) begin errors++; $display("FAIL msb_done_count got=%0d exp=1", dc); end
        checks++; if (res !== 32'h8000_0000) begin errors++; $display("FAIL msb_result got=%h exp=%h", res, 32'h8000_0000); end
    endtask

    task automatic test_mid_zero();
        int lat, bc, dc; logic [31:0] res;
        run_op(32'hFFFF_FFFF, 5'd4, 6'd0, lat, bc, dc, res);
        checks++; if (res !== 32'hFFFF_FFF0) begin errors++; $display("FAIL mid4_result got=%h exp=%h", res, 32'hFFFF_FFF0); end
        checks++; if (lat !== 5) begin errors++; $display("FAIL mid4_latency got=%0d exp=5", lat); end
        run_op(32'h1234_5678, 5'd0, 6'd0, lat, bc, dc, res);
        checks++; if (res !== 32'h1234_5678) begin errors++; $display("FAIL zero_result got=%h exp=%h", res, 32'h1234_5678); end
        checks++; if (lat !== 5) begin errors++; $display("FAIL zero_latency got=%0d exp=5", lat); end
        checks++; if (bc !== 5) begin errors++; $display("FAIL zero_busy_cycles got=%0d exp=5", bc); end
        // MSB shifted out is discarded.
        run_op(32'h8000_0001, 5'd1, 6'd0, lat, bc, dc, res);
        checks++; if (res !== 32'h0000_0002) begin errors++; $display("FAIL drop_msb_result got=%h exp=%h", res, 32'h0000_0002); end
        // 0x0000F0F5 << 19 = 0x87A80000 (stages 1, 2 and 16 active).
        run_op(32'h0000_F0F5, 5'd19, 6'd0, lat, bc, dc, res);
        checks++; if (res !== 32'h87A8_0000) begin errors++; $display("FAIL sh19_result got=%h exp=%h", res, 32'h87A8_0000); end
        // dataOut holds after done.
        @(negedge clk);
        checks++; if (dataOut !== 32'h87A8_0000) begin errors++; $display("FAIL hold_result got=%h exp=%h", dataOut, 32'h87A8_0000); end
    endtask

    task automatic test_ignore_start();
        int dc; logic [31:0] res; int lat; logic [31:0] held;
        dc = 0; lat = -1; res = 'x;
        @(negedge clk);
        held = dataOut;
        dataA = 32'h3; dataB = 5'd2; Signal = 6'd0; start = 1'b1;
        @(posedge clk);
        for (int n = 0; n < 14; n++) begin
            @(negedge clk);
            if (n == 1) begin
                dataA = 32'hA; dataB = 5'd1; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (n == 3) begin
                checks++; if (dataOut !== held) begin errors++; $display("FAIL ign_hold_midop got=%h exp=%h", dataOut, held); end
            end
            if (done) begin
                dc++;
                if (lat < 0) begin lat = n; res = dataOut; end
            end
        end
        checks++; if (dc !== 1) begin errors++; $display("FAIL ign_done_count got=%0d exp=1", dc); end
        checks++; if (res !== 32'h0000_000C) begin errors++; $display("FAIL ign_result got=%h exp=%h", res, 32'h0000_000C); end
        checks++; if (dataOut !== 32'h0000_000C) begin errors++; $display("FAIL ign_final got=%h exp=%h", dataOut, 32'h0000_000C); end
    endtask

    task automatic test_back_to_back();
        int lat2; logic [31:0] res1, res2; logic b_after;
        lat2 = -1; res1 = 'x; res2 = 'x; b_after = 1'bx;
        @(negedge clk);
        dataA = 32'h0000_0F0F; dataB = 5'd8; Signal = 6'd0; start = 1'b1;
        @(posedge clk);
        for (int n = 0; n < 16; n++) begin
            @(negedge clk);
            if (n == 5) begin
                res1 = dataOut;
                checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_done1 got=%b exp=1", done); end
                dataA = 32'hDEAD_BEEF; dataB = 5'd16;
            end
            if (n == 6) begin
                b_after = busy;
                start = 1'b0;
            end
            if (n > 5 && done && lat2 < 0) begin
                lat2 = n;
                res2 = dataOut;
            end
        end
        checks++; if (res1 !== 32'h000F_0F00) begin errors++; $display("FAIL b2b_result1 got=%h exp=%h", res1, 32'h000F_0F00); end
        checks++; if (b_after !== 1'b1) begin errors++; $display("FAIL b2b_no_idle got=%b exp=1", b_after); end
        checks++; if (lat2 !== 11) begin errors++; $display("FAIL b2b_latency2 got=%0d exp=11", lat2); end
        checks++; if (res2 !== 32'hBEEF_0000) begin errors++; $display("FAIL b2b_result2 got=%h exp=%h", res2, 32'hBEEF_0000); end
    endtask

    task automatic test_reset_mid();
        int dc; int lat, bc, dc2; logic [31:0] res;
        dc = 0;
        @(negedge clk);
        dataA = 32'h1; dataB = 5'd8; Signal = 6'd0; start = 1'b1;
        @(posedge clk);            // E0
        @(negedge clk); start = 1'b0;
        @(posedge clk);            // E1
        @(posedge clk);            // E2
        #1 reset = 1'b1;
        #1;
        checks++; if (dataOut !== 32'h0) begin errors++; $display("FAIL rstmid_dataOut got=%h exp=%h", dataOut, 32'h0); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            if (done) dc++;
        end
        reset = 1'b0;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            if (done) dc++;
        end
        checks++; if (dc !== 0) begin errors++; $display("FAIL rstmid_no_done got=%0d exp=0", dc); end
        run_op(32'h1, 5'd8, 6'd0, lat, bc, dc2, res);
        checks++; if (res !== 32'h0000_0100) begin errors++; $display("FAIL rstmid_after got=%h exp=%h", res, 32'h0000_0100); end
        checks++; if (lat !== 5) begin errors++; $display("FAIL rstmid_after_lat got=%0d exp=5", lat); end
    endtask

`ifdef SHIFTER_SRL_EN
    task automatic test_srl();
        int lat, bc, dc; logic [31:0] res;
        run_op(32'h8000_0000, 5'd31, 6'b000010, lat, bc, dc, res);
        checks++; if (res !== 32'h0000_0001) begin errors++; $display("FAIL srl_result got=%h exp=%h", res, 32'h0000_0001); end
        checks++; if (lat !== 5) begin errors++; $display("FAIL srl_latency got=%0d exp=5", lat); end
        run_op(32'h8000_0000, 5'd31, 6'b000000, lat, bc, dc, res);
        checks++; if (res !== 32'h0000_0000) begin errors++; $display("FAIL srl_left_result got=%h exp=%h", res, 32'h0000_0000); end
    endtask
`else
    task automatic test_signal_ignored();
        int lat, bc, dc; logic [31:0] res;
        run_op(32'h0000_0003, 5'd4, 6'b000010, lat, bc, dc, res);
        checks++; if (res !== 32'h0000_0030) begin errors++; $display("FAIL sig_ignored got=%h exp=%h", res, 32'h0000_0030); end
    endtask
`endif

    initial begin
        errors = 0;
        checks = 0;
        reset  = 1'b1;
        start  = 1'b0;
        dataA  = '0;
        dataB  = '0;
        Signal = '0;
        test_reset();
        test_shift_msb();
        test_mid_zero();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
`ifdef SHIFTER_SRL_EN
        test_srl();
`else
        test_signal_ignored();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout got=running exp=finished");
        $fatal(1, "watchdog");
    end

endmodule
